cpu_readpath: RTL and testbench
===============================

# cpu_readpath

Load-return buffer sitting directly upstream of the COM stage's memory port. It records each load issued to data memory, and captures the in-order read responses. It aligns and sign/zero-extends each response, then holds the formatted result until COM has a free register-file write slot. It replaces ad-hoc load writeback so that loads never stall waiting for an ALU bubble; only a full buffer back-pressures issue.

## Interface
Parameters:
- DEPTH, 4, number of in-flight plus completed-but-unwritten loads; power of two, ≥2.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  a load is issued to data memory this cycle
- req_ready  output  1  buffer can accept a load request (count < DEPTH)
- req_dest  input  5  destination register of the load
- req_size  input  2  00 byte, 01 half, 10 word (11 reserved, treated as word)
- req_signed  input  1  sign-extend sub-word result
- req_addr_lo  input  2  low address bits for lane select
- dmem_rvalid  input  1  read data returned (in request order)
- dmem_rdata  input  32  raw 32-bit memory word
- mem_ready  input  1  COM is writing mem_dest/mem_result this cycle
- mem_dest  output  5  destination of head result; 0 when no result ready
- mem_result  output  32  formatted head result; 0 when no result ready
- load_misaligned  output  1  one-cycle pulse (only with check enabled)
- protocol_err  output  1  sticky error flag

## Operation
- Circular buffer of DEPTH entries, each holding dest, size, signed, addr_lo, data, done.
- Three pointers (log2(DEPTH)+1 bits with wrap bit): alloc, fill, drain.
- Allocate: req_valid && req_ready → write entry[alloc] with done=0; alloc++.
- Fill: dmem_rvalid → entry[fill].data = formatted dmem_rdata; done=1; fill++.
- Formatting:
  - Byte: lane = addr_lo.
  - Half: lane = addr_lo[1].
  - Word: passthrough.
  - Sub-word values are zero- or sign-extended to 32 bits per req_signed.
- Drain: the head is valid when drain≠fill, i.e. entry[drain].done.
  - mem_dest/mem_result come from the head when it is valid, else 0/0. Writing x0 is harmless to COM.
  - Head valid && mem_ready → drain++.
  - mem_ready with no valid head: no effect.
- Loads with req_dest=0 occupy an entry and drain normally, delivering dest 0.
- count = alloc − drain; req_ready = (count < DEPTH).
  - The request is taken from the registered count; a pop in the same cycle does not free a slot until the next cycle.
- protocol_err is set by either of these, and cleared only by reset:
  - req_valid while !req_ready: the request is dropped.
  - dmem_rvalid with fill==alloc: the response is dropped.
- Allocate, fill and drain may all occur in the same cycle. A response may complete an entry allocated in an earlier cycle, never one allocated the same cycle.

## Timing
- Reset values:
  - All pointers 0; all done bits 0.
  - req_ready=1, mem_dest=0, mem_result=0, load_misaligned=0, protocol_err=0.
- Response at edge N → mem_dest/mem_result valid after edge N. Removed after the first edge at which mem_ready=1.
- mem_dest/mem_result are driven from registered entry state only. There is no combinational path from dmem_rdata or mem_ready to them.
- req_ready depends only on registered state.
- Reset asserted mid-operation: all in-flight and completed entries are discarded immediately. Responses returning after reset deassertion set protocol_err.

## Configuration
- CPU_READPATH_MISALIGN_CHECK_EN defined:
  - A half request with addr_lo[0]=1, or a word request with addr_lo≠0, is not allocated.
  - load_misaligned pulses for one cycle (gated by req_ready).
  - The issuer must not expect a response.
- Not defined: load_misaligned is tied 0. Misaligned requests are allocated and formatted using the lane bits as given, ignoring the invalid low bit.

## Structure
- Shared header (alongside the existing op encodings): load-size constants LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10.
- Sub-module cpu_load_format: combinational lane select plus extension. Inputs are (rdata, size, signed, addr_lo); output is the 32-bit result. It is instantiated once on the fill path.

## Test plan
- Single load:
  - Stimulus: req_dest=5, word, then dmem_rdata=0xDEADBEEF, mem_ready held 1.
  - Response: mem_dest=5 and mem_result=0xDEADBEEF for exactly one cycle, then 0/0.
- Byte extension: addr_lo=3, data 0x80123456. Signed → 0xFFFFFF80; unsigned → 0x00000080. Half, addr_lo=2, signed, data 0x8001xxxx → 0xFFFF8001.
- Back-pressure:
  - Stimulus: 4 loads issued, mem_ready=0, all responses return.
  - Response: req_ready=0. A 5th req_valid sets protocol_err. Releasing mem_ready drains dests in issue order, one per cycle.
- Simultaneous events: one cycle with an allocate, a fill of an older entry and a drain of the head. Count is unchanged and the order is preserved.
- Stray response: dmem_rvalid with the buffer empty → protocol_err=1, outputs stay 0/0.
- With CPU_READPATH_MISALIGN_CHECK_EN: word load with addr_lo=1 → load_misaligned pulse, count unchanged. A following aligned load completes normally.

Source files
------------

// File: rtl/cpu_readpath_pkg.sv
// Shared load-path definitions: load-size encodings and the alignment rule
// used by the optional misaligned-load check.
package cpu_readpath_pkg;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  // Reserved size 2'b11 behaves as a word, so it shares the word alignment rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      LS_BYTE: mis = 1'b0;
      LS_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/cpu_readpath_load_format.sv
// cpu_load_format: lane select of a raw memory word plus zero/sign extension
// of byte and half results to 32 bits.
module cpu_load_format
  import cpu_readpath_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane and extend it to full width.
  always_comb begin
    byte_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      LS_BYTE: result_o = {{24{signed_i & byte_s[7]}}, byte_s};
      LS_HALF: result_o = {{16{signed_i & half_s[15]}}, half_s};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/cpu_readpath.sv
// Load-return buffer: records issued loads, captures in-order responses already
// formatted, and holds them until COM writes them back. Optional misaligned-load
// rejection is enabled by defining CPU_READPATH_MISALIGN_CHECK_EN.
module cpu_readpath
  import cpu_readpath_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_dest,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [1:0]  req_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        mem_ready,
  output logic [4:0]  mem_dest,
  output logic [31:0] mem_result,
  output logic        load_misaligned,
  output logic        protocol_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   alloc_q, alloc_d, fill_q, fill_d, drain_q, drain_d;
  logic [PTR_W:0]   count_s;
  logic [PTR_W-1:0] alloc_idx_s, fill_idx_s, drain_idx_s;
  logic [4:0]       dest_q  [DEPTH];
  logic [1:0]       size_q  [DEPTH];
  logic             sgn_q   [DEPTH];
  logic [1:0]       lo_q    [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [DEPTH-1:0] done_q;
  logic             err_q, err_d;
  logic             misaligned_s, alloc_s, fill_s, drain_s, head_valid_s;
  logic [31:0]      fmt_s;

  assign alloc_idx_s = alloc_q[PTR_W-1:0];
  assign fill_idx_s  = fill_q[PTR_W-1:0];
  assign drain_idx_s = drain_q[PTR_W-1:0];
  assign count_s     = alloc_q - drain_q;
  assign req_ready   = (count_s < (PTR_W+1)'(DEPTH));

`ifdef CPU_READPATH_MISALIGN_CHECK_EN
  logic mis_q;
  assign misaligned_s = is_misaligned(req_size, req_addr_lo);

  // One-cycle pulse for a misaligned request that would otherwise have been taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= req_valid & req_ready & misaligned_s;
  end
  assign load_misaligned = mis_q;
`else
  assign misaligned_s    = 1'b0;
  assign load_misaligned = 1'b0;
`endif

  cpu_load_format u_fmt (
    .rdata_i   (dmem_rdata),
    .size_i    (size_q[fill_idx_s]),
    .signed_i  (sgn_q[fill_idx_s]),
    .addr_lo_i (lo_q[fill_idx_s]),
    .result_o  (fmt_s)
  );

  // Pointer advance and sticky protocol error detection.
  always_comb begin
    alloc_s      = req_valid & req_ready & ~misaligned_s;
    fill_s       = dmem_rvalid & (fill_q != alloc_q);
    head_valid_s = done_q[drain_idx_s];
    drain_s      = head_valid_s & mem_ready;
    alloc_d      = alloc_q + (PTR_W+1)'(alloc_s);
    fill_d       = fill_q + (PTR_W+1)'(fill_s);
    drain_d      = drain_q + (PTR_W+1)'(drain_s);
    err_d        = err_q | (req_valid & ~req_ready) | (dmem_rvalid & (fill_q == alloc_q));
  end

  // Pointer and error state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alloc_q <= '0;
      fill_q  <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

  // Entry storage; alloc, fill and drain never target the same live slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= 5'd0;
        size_q[i] <= 2'b00;
        sgn_q[i]  <= 1'b0;
        lo_q[i]   <= 2'b00;
        data_q[i] <= 32'd0;
      end
    end else begin
      if (alloc_s) begin
        dest_q[alloc_idx_s] <= req_dest;
        size_q[alloc_idx_s] <= req_size;
        sgn_q[alloc_idx_s]  <= req_signed;
        lo_q[alloc_idx_s]   <= req_addr_lo;
        done_q[alloc_idx_s] <= 1'b0;
      end
      if (fill_s) begin
        data_q[fill_idx_s] <= fmt_s;
        done_q[fill_idx_s] <= 1'b1;
      end
      if (drain_s) begin
        done_q[drain_idx_s] <= 1'b0;
      end
    end
  end

  assign mem_dest     = head_valid_s ? dest_q[drain_idx_s] : 5'd0;
  assign mem_result   = head_valid_s ? data_q[drain_idx_s] : 32'd0;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_cpu_readpath.sv
// Directed self-checking bench for cpu_readpath (DEPTH=4).
module tb_cpu_readpath;
  import cpu_readpath_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_dest = 5'd0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [1:0]  req_addr_lo = 2'b00;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic        load_misaligned;
  logic        protocol_err;

  int n_cmp = 0;
  int n_err = 0;

  cpu_readpath #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest),
    .req_size(req_size), .req_signed(req_signed), .req_addr_lo(req_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_result(mem_result),
    .load_misaligned(load_misaligned), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] d, input logic [1:0] sz, input logic sg, input logic [1:0] lo);
    req_valid = 1'b1; req_dest = d; req_size = sz; req_signed = sg; req_addr_lo = lo;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    dmem_rvalid = 1'b1; dmem_rdata = data;
    tick();
    dmem_rvalid = 1'b0;
  endtask

  // Issue one load, return its data, check the formatted head, then let it drain.
  task automatic load_check(input string tag, input logic [4:0] d, input logic [1:0] sz,
                            input logic sg, input logic [1:0] lo, input logic [31:0] data,
                            input logic [31:0] exp);
    issue(d, sz, sg, lo);
    respond(data);
    check_eq({tag, "_dest"}, 32'(mem_dest), 32'(d));
    check_eq({tag, "_res"}, mem_result, exp);
    tick();
    check_eq({tag, "_gone"}, 32'(mem_dest) | mem_result, 32'd0);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_dest", 32'(mem_dest), 32'd0);
    check_eq("rst_res", mem_result, 32'd0);
    check_eq("rst_mis", 32'(load_misaligned), 32'd0);
    check_eq("rst_err", 32'(protocol_err), 32'd0);

    // Single load: not visible before the response, visible one cycle after it.
    mem_ready = 1'b1;
    issue(5'd5, LS_WORD, 1'b0, 2'd0);
    check_eq("single_pre", 32'(mem_dest), 32'd0);
    respond(32'hDEADBEEF);
    check_eq("single_dest", 32'(mem_dest), 32'd5);
    check_eq("single_res", mem_result, 32'hDEADBEEF);
    tick();
    check_eq("single_gone_d", 32'(mem_dest), 32'd0);
    check_eq("single_gone_r", mem_result, 32'd0);

    load_check("b_s3", 5'd7, LS_BYTE, 1'b1, 2'd3, 32'h80123456, 32'hFFFFFF80);
    load_check("b_u3", 5'd8, LS_BYTE, 1'b0, 2'd3, 32'h80123456, 32'h00000080);
    load_check("b_u1", 5'd9, LS_BYTE, 1'b0, 2'd1, 32'h80123456, 32'h00000034);
    load_check("h_s2", 5'd11, LS_HALF, 1'b1, 2'd2, 32'h80011234, 32'hFFFF8001);
    load_check("h_u0", 5'd12, LS_HALF, 1'b0, 2'd0, 32'h1234F00D, 32'h0000F00D);
    load_check("dest0", 5'd0, LS_WORD, 1'b0, 2'd0, 32'h13572468, 32'h13572468);

`ifdef CPU_READPATH_MISALIGN_CHECK_EN
    issue(5'd9, LS_WORD, 1'b0, 2'd1);
    check_eq("mis_pulse", 32'(load_misaligned), 32'd1);
    tick();
    check_eq("mis_end", 32'(load_misaligned), 32'd0);
    load_check("mis_next", 5'd14, LS_WORD, 1'b0, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D);
`else
    issue(5'd15, LS_WORD, 1'b0, 2'd1);
    check_eq("mis_off", 32'(load_misaligned), 32'd0);
    respond(32'h11223344);
    check_eq("mis_off_dest", 32'(mem_dest), 32'd15);
    check_eq("mis_off_res", mem_result, 32'h11223344);
    tick();
`endif

    // Simultaneous allocate, fill and drain keep count and order.
    mem_ready = 1'b0;
    issue(5'd1, LS_WORD, 1'b0, 2'd0);
    issue(5'd2, LS_WORD, 1'b0, 2'd0);
    respond(32'h0000000A);
    check_eq("sim_headA", 32'(mem_dest), 32'd1);
    req_valid = 1'b1; req_dest = 5'd3; req_size = LS_WORD; req_addr_lo = 2'd0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000000B; mem_ready = 1'b1;
    tick();
    req_valid = 1'b0; dmem_rvalid = 1'b0; mem_ready = 1'b0;
    check_eq("sim_headB_d", 32'(mem_dest), 32'd2);
    check_eq("sim_headB_r", mem_result, 32'h0000000B);
    issue(5'd4, LS_WORD, 1'b0, 2'd0);
    check_eq("sim_cnt3", 32'(req_ready), 32'd1);
    issue(5'd5, LS_WORD, 1'b0, 2'd0);
    check_eq("sim_full", 32'(req_ready), 32'd0);
    respond(32'h0000000C);
    respond(32'h0000000D);
    respond(32'h0000000E);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("sim_order_d", 32'(mem_dest), 32'(i + 2));
      check_eq("sim_order_r", mem_result, 32'(i + 11));
      tick();
    end
    check_eq("sim_empty", 32'(mem_dest), 32'd0);
    check_eq("sim_noerr", 32'(protocol_err), 32'd0);

    // Back-pressure: four outstanding, a fifth request is dropped and flagged.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(5'(10 + i), LS_WORD, 1'b0, 2'd0);
    check_eq("bp_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) respond(32'(256 + i));
    check_eq("bp_err0", 32'(protocol_err), 32'd0);
    issue(5'd20, LS_WORD, 1'b0, 2'd0);
    check_eq("bp_err1", 32'(protocol_err), 32'd1);
    check_eq("bp_hold", 32'(mem_dest), 32'd10);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_drain_d", 32'(mem_dest), 32'(10 + i));
      check_eq("bp_drain_r", mem_result, 32'(256 + i));
      tick();
    end
    check_eq("bp_empty", 32'(mem_dest), 32'd0);
    check_eq("bp_ready2", 32'(req_ready), 32'd1);

    // Reset mid-operation discards entries; a late response is a stray.
    mem_ready = 1'b0;
    issue(5'd21, LS_WORD, 1'b0, 2'd0);
    issue(5'd22, LS_WORD, 1'b0, 2'd0);
    respond(32'h55AA55AA);
    check_eq("mid_head", 32'(mem_dest), 32'd21);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_d", 32'(mem_dest), 32'd0);
    check_eq("mid_rst_err", 32'(protocol_err), 32'd0);
    tick();
    reset = 1'b0;
    check_eq("mid_ready", 32'(req_ready), 32'd1);
    respond(32'h77777777);
    check_eq("stray_err", 32'(protocol_err), 32'd1);
    check_eq("stray_d", 32'(mem_dest), 32'd0);
    check_eq("stray_r", mem_result, 32'd0);
    tick();
    check_eq("stray_sticky", 32'(protocol_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
